scan_chain_ctrl: RTL and testbench

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_pkg.sv | 17 +
 rtl/scan_misr.sv | 27 ++
 rtl/scan_chain_ctrl.sv | 143 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain controller: FSM states and MISR constants.
// The MISR itself is only built when SCAN_CHAIN_CTRL_MISR_EN is defined.
package scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/scan_misr.sv
// 16-bit serial-input signature register folding one scan-out bit per enabled cycle.
module scan_misr
    import scan_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        din,
    input  logic        clr,
    output logic [15:0] sig
);

    logic fb;

    assign fb = sig[15] ^ din;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sig <= '0;
        end else if (clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load/capture/unload scan test sequencer with response compare.
// Define SCAN_CHAIN_CTRL_MISR_EN to add the SIG signature output.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    output logic                 SE,
    output logic                 SD,
    input  logic                 SO,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [CHAIN_LEN-1:0] RESP
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    ,
    output logic [15:0]          SIG
`endif
);

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] cap_q;
    logic [CHAIN_LEN-1:0] cap_nxt;
    logic [CHAIN_LEN-1:0] resp_q;
    logic                 pass_q;
    logic                 last;
    logic                 start_acc;
    logic                 abort_act;

    assign last      = (cnt == CW'(CHAIN_LEN - 1));
    assign start_acc = (state == S_IDLE) && START && !ABORT;
    assign abort_act = (state != S_IDLE) && ABORT;
    // Tail flop unloads first, so each sample enters at the top and ripples down.
    assign cap_nxt   = {SO, cap_q[CHAIN_LEN-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_act) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (start_acc) state_nxt = S_LOAD;
                S_LOAD:    if (last) state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = S_UNLOAD;
                S_UNLOAD:  if (last) state_nxt = S_DONE;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        SE   = 1'b0;
        SD   = 1'b0;
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state)
            S_IDLE: ;
            S_LOAD: begin
                SE   = 1'b1;
                SD   = pat_q[0];
                BUSY = 1'b1;
            end
            S_CAPTURE: BUSY = 1'b1;
            S_UNLOAD: begin
                SE   = 1'b1;
                BUSY = 1'b1;
            end
            S_DONE: begin
                DONE = 1'b1;
                BUSY = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            pat_q  <= '0;
            exp_q  <= '0;
            cap_q  <= '0;
            resp_q <= '0;
            pass_q <= 1'b0;
        end else if (start_acc) begin
            cnt   <= '0;
            pat_q <= PAT_IN;
            exp_q <= EXP_IN;
        end else if (abort_act) begin
            cnt <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    pat_q <= {1'b0, pat_q[CHAIN_LEN-1:1]};
                    cnt   <= last ? '0 : cnt + CW'(1);
                end
                S_UNLOAD: begin
                    cap_q <= cap_nxt;
                    cnt   <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        resp_q <= cap_nxt;
                        pass_q <= (cap_nxt == exp_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign RESP = resp_q;
    assign PASS = pass_q;

`ifdef SCAN_CHAIN_CTRL_MISR_EN
    scan_misr u_misr (
        .CLK (CLK),
        .RST (RST),
        .en  ((state == S_UNLOAD) && !ABORT),
        .din (SO),
        .clr (start_acc),
        .sig (SIG)
    );
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench: 8-flop inverting scan chain around scan_chain_ctrl.
// Build with SCAN_CHAIN_CTRL_MISR_EN to also check SIG.
module tb_scan_chain_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [7:0] PAT_IN = '0;
    logic [7:0] EXP_IN = '0;
    logic       SE;
    logic       SD;
    logic       SO;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [7:0] RESP;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    logic [15:0] SIG;
`endif

    typedef struct packed {
        logic [7:0]  resp;
        logic        pass;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    logic [31:0] cyc = 0;
    logic [7:0]  chain;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Mux-D scan flops; functional D is the flop's own inverted Q.
    always @(posedge CLK or posedge RST) begin
        if (RST) chain <= '0;
        else if (SE) chain <= {chain[6:0], SD};
        else chain <= ~chain;
    end
    assign SO = chain[7];

    scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .ABORT  (ABORT),
        .PAT_IN (PAT_IN),
        .EXP_IN (EXP_IN),
        .SE     (SE),
        .SD     (SD),
        .SO     (SO),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .PASS   (PASS),
        .RESP   (RESP)
`ifdef SCAN_CHAIN_CTRL_MISR_EN
        ,
        .SIG    (SIG)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    function automatic logic [15:0] misr_ref(input logic [7:0] r);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int k = 0; k < 8; k++) begin
            if (s[15] ^ r[k]) s = {s[14:0], 1'b0} ^ 16'h1021;
            else s = {s[14:0], 1'b0};
        end
        return s;
    endfunction

    // Monitor: every DONE pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && DONE) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", RESP, e.resp);
                    check("pass", PASS, e.pass);
                    check("latency", cyc - e.cyc + 1, 32'd18);
`ifdef SCAN_CHAIN_CTRL_MISR_EN
                    check("sig", SIG, misr_ref(e.resp));
`endif
                end
            end
        end
    end

    task automatic run_test(input logic [7:0] pat, input logic [7:0] ev,
                            input logic [7:0] resp_e, input logic pass_e,
                            input bit repulse);
        logic [17:0] se_v;
        logic [7:0]  sd_v;
        se_v = '0;
        sd_v = '0;
        @(negedge CLK);
        PAT_IN = pat;
        EXP_IN = ev;
        START = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.push_back('{resp_e, pass_e, cyc});
        START = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLK);
            se_v[k-1] = SE;
            if (k <= 8) sd_v[k-1] = SD;
            if (repulse) begin
                if (k == 2) begin
                    START = 1'b1;
                    PAT_IN = 8'hFF;
                    EXP_IN = 8'h00;
                end
                if (k == 3) START = 1'b0;
                if (k == 18) START = 1'b1;
            end
        end
        check("se_seq", 32'(se_v), 32'h1FEFF);
        check("sd_seq", 32'(sd_v), 32'(pat));
        @(negedge CLK);
        check("idle_after", BUSY, 1'b0);
        START = 1'b0;
    endtask

    initial begin
        int d0;
        #1;
        check("rst_outs", {SE, SD, BUSY, DONE, PASS}, 5'b0);
        check("rst_resp", RESP, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        run_test(8'hA5, 8'h5A, 8'h5A, 1'b1, 1'b0);
        run_test(8'hA5, 8'h52, 8'h5A, 1'b0, 1'b0);

        // Abort in the third UNLOAD cycle.
        d0 = done_cnt;
        @(negedge CLK);
        PAT_IN = 8'h3C;
        EXP_IN = 8'hC3;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int k = 1; k <= 12; k++) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_se", SE, 1'b0);
        check("abort_busy", BUSY, 1'b0);
        check("abort_resp", RESP, 8'h5A);
        check("abort_pass", PASS, 1'b0);
        repeat (20) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 32'd0);

        // START re-pulsed in LOAD and in the DONE cycle.
        d0 = done_cnt;
        run_test(8'h0F, 8'hF0, 8'hF0, 1'b1, 1'b1);
        repeat (5) @(negedge CLK);
        check("repulse_busy", BUSY, 1'b0);
        check("repulse_one_done", done_cnt - d0, 32'd1);

        // Asynchronous reset in the fourth LOAD cycle.
        @(negedge CLK);
        PAT_IN = 8'h81;
        EXP_IN = 8'h7E;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge CLK);
        check("pre_rst_busy", BUSY, 1'b1);
        RST = 1'b1;
        #1;
        check("midrst_outs", {SE, SD, BUSY, DONE, PASS}, 5'b0);
        check("midrst_resp", RESP, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        run_test(8'h81, 8'h7E, 8'h7E, 1'b1, 1'b0);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge CLK);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
